signed_serial_subtractor: RTL



---
 rtl/signed_sub_pkg.sv | 20 ++
 rtl/full_adder_1b.sv | 13 +
 rtl/signed_serial_subtractor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/signed_sub_pkg.sv
// Shared types and helpers for the bit-serial signed subtractor.
package signed_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold an index in 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder used as the serial datapath of the subtractor.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/signed_serial_subtractor.sv
// Bit-serial signed a - b, LSB first, with start/ready/valid handshake.
// Optional saturated output enabled by defining SIGNED_SUB_SATURATE_EN.
module signed_serial_subtractor
  import signed_sub_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            ready,
  output logic            valid,
  output logic [SIZE:0]   result,
`ifdef SIGNED_SUB_SATURATE_EN
  output logic [SIZE-1:0] sat_result,
`endif
  output logic            overflow
);

  localparam int IDX_W = clog2(SIZE);

  state_t            state_q, state_d;
  logic [SIZE-1:0]   a_q, a_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [SIZE:0]     result_q, result_d;
  logic              overflow_q, overflow_d;
  logic [SIZE-1:0]   sat_q, sat_d;

  logic fa_sum;
  logic fa_cout;
  logic b_inv;
  logic msb_new;
  logic [SIZE-1:0] low_new;

  // Operands shift right each cycle so bit 0 is always the active bit.
  assign b_inv = ~b_q[0];

  full_adder_1b u_fa (
    .a    (a_q[0]),
    .b    (b_inv),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign msb_new = a_q[0] ^ b_inv ^ fa_cout;
  assign low_new = {fa_sum, result_q[SIZE-2:0]};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    ready_d    = ready_q;
    valid_d    = valid_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    sat_d      = sat_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b1;
          idx_d   = '0;
          ready_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        result_d[idx_q] = fa_sum;
        carry_d         = fa_cout;
        a_d             = a_q >> 1;
        b_d             = b_q >> 1;
        idx_d           = idx_q + 1'b1;
        if (idx_q == IDX_W'(SIZE - 1)) begin
          // carry_q is the carry into the MSB, fa_cout the carry out of it.
          result_d[SIZE] = msb_new;
          overflow_d     = carry_q ^ fa_cout;
          if (carry_q ^ fa_cout)
            sat_d = msb_new ? {1'b1, {(SIZE-1){1'b0}}} : {1'b0, {(SIZE-1){1'b1}}};
          else
            sat_d = low_new;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      sat_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      sat_q      <= sat_d;
    end
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign result   = result_q;
  assign overflow = overflow_q;
`ifdef SIGNED_SUB_SATURATE_EN
  assign sat_result = sat_q;
`else
  logic unused_sat;
  assign unused_sat = ^sat_q;
`endif

endmodule
